// File: rtl/store_merge_if.sv
// store_merge_if -- bundle of the store request channel and the memory port
// of store_merge_unit.
//
// Parameters
//   DATA_W  memory word width in bits
//   ADDR_W  byte-address width in bits
//
// Signals
//   req_valid / req_ready      request handshake (transfer when both are 1)
//   req_addr, req_size         store byte address and size code (0..3 = 1,2,4,8 bytes)
//   req_data                   store data, right-aligned
//   mem_addr                   word-aligned memory address
//   mem_rd_en / mem_rdata      read strobe and read data (RD_LAT cycles later)
//   mem_wr_en / mem_wdata      write strobe and merged write word
//   done_valid / misalign_err  completion pulse and its reject qualifier
//
// Modports
//   slave   the merge unit's view
//   master  the requester/memory side's view
interface store_merge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;

    logic              done_valid;
    logic              misalign_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_data, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               done_valid, misalign_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_data, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               done_valid, misalign_err
    );
endinterface

// File: rtl/store_merge_unit.sv
// store_merge_unit -- turns byte/half/word/dword stores into whole-word memory
// writes. Sub-width stores do a read-modify-write of the containing word;
// full-width aligned stores are written directly; misaligned stores are
// rejected with a flagged completion pulse and no memory traffic.
//
// Parameters
//   DATA_W  memory word width, 32 or 64
//   ADDR_W  byte-address width
//   RD_LAT  cycles from mem_rd_en to valid mem_rdata, 1..4
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        store_merge_if.slave: request channel, memory port, completion
//   dbg_state  current FSM state encoding (IDLE=0 READ=1 WAIT=2 WRITE=3 RESP=4)
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    store_merge_if.slave    bus,
    output logic [2:0]      dbg_state
);
    localparam int NB = DATA_W / 8;     // bytes per memory word
    localparam int LB = $clog2(NB);     // lane-offset bits

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state, state_n;

    logic [2:0]        wait_cnt;
    logic [LB-1:0]     cap_off;
    logic [1:0]        cap_size;
    logic [DATA_W-1:0] cap_data;

    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              mis_q;

    logic              hs;
    logic [LB-1:0]     req_off;
    logic              req_mis;
    logic              req_full;

    logic [DATA_W-1:0] data_sh;
    logic [NB-1:0]     lane_en;
    logic [DATA_W-1:0] merged;

    // Handshake: a request transfers in any cycle where req_valid and
    // req_ready are both 1. req_ready is 1 exactly in IDLE and does not
    // depend on req_valid; the requester holds its fields stable while
    // req_valid is 1 and ready is 0. Everything after the transfer works
    // from captured copies, so request inputs may change freely afterwards.
    assign hs      = bus.req_valid && (state == IDLE);
    assign req_off = bus.req_addr[LB-1:0];

    // Alignment: offset must be a multiple of the store size; a dword
    // store cannot fit a 32-bit word at all.
    always_comb begin
        req_mis = 1'b0;
        unique case (bus.req_size)
            2'd0: req_mis = 1'b0;
            2'd1: req_mis = req_off[0];
            2'd2: req_mis = |req_off[1:0];
            2'd3: req_mis = (DATA_W == 32) ? 1'b1 : |req_off;
            default: req_mis = 1'b1;
        endcase
        req_full = !req_mis && (int'(bus.req_size) == LB);
    end

    // Byte-lane merge of the captured store into the word returned by memory.
    always_comb begin
        data_sh = cap_data << {cap_off, 3'b000};
        lane_en = '0;
        merged  = '0;
        for (int i = 0; i < NB; i++) begin
            lane_en[i] = (i >= int'(cap_off)) &&
                         (i < int'(cap_off) + (1 << cap_size));
            merged[i*8 +: 8] = lane_en[i] ? data_sh[i*8 +: 8]
                                          : bus.mem_rdata[i*8 +: 8];
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (hs) begin
                    if (req_mis)       state_n = RESP;
                    else if (req_full) state_n = WRITE;
                    else               state_n = READ;
                end
            end
            READ:    state_n = WAIT;
            WAIT:    if (wait_cnt == 3'd0) state_n = WRITE;
            WRITE:   state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Strobes are registered from the next state so each one lines up with
    // the cycle its state is occupied, with no path from req_* to mem_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 3'd0;
            cap_off  <= '0;
            cap_size <= 2'd0;
            cap_data <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            rd_en_q <= (state_n == READ);
            wr_en_q <= (state_n == WRITE);
            done_q  <= (state_n == RESP);
            mis_q   <= hs && req_mis;

            if (hs) begin
                cap_off  <= req_off;
                cap_size <= bus.req_size;
                cap_data <= bus.req_data;
                addr_q   <= {bus.req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                if (req_full) wdata_q <= bus.req_data;
            end

            // Down-counter sized so WAIT spans RD_LAT cycles; read data is
            // only sampled on the last one.
            if (state == READ)
                wait_cnt <= 3'(RD_LAT - 1);
            else if (state == WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;

            if (state == WAIT && wait_cnt == 3'd0)
                wdata_q <= merged;
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.done_valid   = done_q;
    assign bus.misalign_err = mis_q;
    assign dbg_state        = state;
endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The parameter DATA_W SHALL default to 32, set the memory word width, and accept only 32 or 64.
REQ-002 The parameter ADDR_W SHALL default to 32 and set the byte-address width.
REQ-003 The parameter RD_LAT SHALL default to 1, accept 1..4, and give the cycles from mem_rd_en to valid mem_rdata.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  store request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_addr  input  ADDR_W  store byte address.
REQ-009 req_size  input  2  0=byte, 1=half, 2=word, 3=dword.
REQ-010 req_data  input  DATA_W  store data, right-aligned.
REQ-011 mem_addr  output  ADDR_W  word-aligned address, low log2(DATA_W/8) bits zero.
REQ-012 mem_rd_en  output  1  one-cycle read strobe.
REQ-013 mem_rdata  input  DATA_W  read data, valid RD_LAT cycles after mem_rd_en.
REQ-014 mem_wr_en  output  1  one-cycle write strobe.
REQ-015 mem_wdata  output  DATA_W  merged write word.
REQ-016 done_valid  output  1  one-cycle completion pulse.
REQ-017 misalign_err  output  1  qualifies done_valid; request rejected.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WAIT, WRITE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid&&req_ready.
REQ-020 At handshake the unit SHALL capture addr, size and data; input changes after the handshake SHALL be ignored.
REQ-021 The lane offset OFF SHALL be req_addr[log2(DATA_W/8)-1:0], and the store byte count N SHALL be 2^req_size.
REQ-022 A request SHALL be misaligned if OFF is not a multiple of N, or if req_size=3 with DATA_W=32.
REQ-023 A misaligned request SHALL go IDLE->RESP and pulse done_valid with misalign_err=1, with no mem_rd_en and no mem_wr_en.
REQ-024 A full-width aligned store (N=DATA_W/8) SHALL go IDLE->WRITE with no read, writing mem_wdata=req_data.
REQ-025 A sub-width store SHALL go IDLE->READ->WAIT->WRITE->RESP.
REQ-026 READ SHALL last 1 cycle with mem_rd_en=1.
REQ-027 WAIT SHALL last RD_LAT cycles, counted by a down-counter, and the unit SHALL register mem_rdata in the last WAIT cycle.
REQ-028 The merge SHALL replace bytes OFF..OFF+N-1 of the captured read word with bytes 0..N-1 of the captured req_data, keeping all other bytes.
REQ-029 WRITE SHALL last 1 cycle with mem_wr_en=1, mem_addr held, and mem_wdata equal to the merged word.
REQ-030 RESP SHALL last 1 cycle with done_valid=1, then return to IDLE; misalign_err SHALL be 0 for valid stores.
REQ-031 Latency from handshake cycle T: misaligned done at T+1; full-width write at T+1 and done at T+2; sub-width rd_en at T+1, write at T+2+RD_LAT, done at T+3+RD_LAT.
REQ-032 mem_addr SHALL hold a stable value from READ through WRITE.
REQ-033 All outputs except req_ready SHALL be driven from registers only, with no combinational path from req_* to mem_*.
REQ-034 mem_rd_en, mem_wr_en and done_valid SHALL never be asserted in the same cycle.
REQ-035 mem_rdata SHALL be ignored outside the last WAIT cycle.

Reset
REQ-036 While rst_n=0, the FSM SHALL be in IDLE and the WAIT counter SHALL be 0.
REQ-037 While rst_n=0, mem_rd_en, mem_wr_en, done_valid and misalign_err SHALL be 0, and mem_addr and mem_wdata SHALL be all zeros.
REQ-038 req_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-039 Reset asserted mid-operation SHALL abort the request; no write or done for it SHALL occur after release.

Verification (DATA_W=32, RD_LAT=1)
REQ-040 SB addr=0x101, data=0xAB, mem_rdata=0x11223344 -> mem_addr=0x100, rd_en at T+1, wr_en at T+3 with wdata=0x1122AB44, done at T+4.
REQ-041 SH addr=0x202, data=0xBEEF, mem_rdata=0x11223344 -> wdata=0xBEEF3344 at T+3, done at T+4, misalign_err=0.
REQ-042 SW addr=0x308, data=0xDEADBEEF -> no rd_en, wr_en at T+1 with mem_addr=0x308 and wdata=0xDEADBEEF, done at T+2.
REQ-043 SH addr=0x403, and separately req_size=3 -> done at T+1 with misalign_err=1, no rd_en, no wr_en.
REQ-044 SB request with rst_n pulsed low during WAIT -> all outputs 0, no wr_en after release, req_ready=1 the next cycle.
REQ-045 Back-to-back SB requests with req_valid held high -> second handshake in the cycle after RESP, req_ready=0 throughout the first request; repeat with RD_LAT=4 (write at T+6).
